// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage and the instruction memory.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues requests to instruction
// memory and loads the IF/ID register that feeds decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle out of reset; no request, only a redirect is taken
// RUN   | fetching; held until the next reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_stage_if.master imem,
  input  logic        stall,
  input  logic        jumpTake,
  input  logic [31:0] jumpTarget,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        bubble,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        valid_id;
  logic [31:0] redirect_pc;

  // Instructions are word aligned, so a redirect drops the low two bits.
  assign redirect_pc = {jumpTarget[31:2], 2'b00};

  // Sequencer, PC and IF/ID register; redirect beats stall beats a returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_id    <= NOP_INST;
      pc_id       <= RESET_PC;
      valid_id    <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          if (jumpTake) begin
            pc <= redirect_pc;
          end
        end
        RUN: begin
          if (jumpTake) begin
            // The word returned this cycle belongs to the wrong path.
            pc       <= redirect_pc;
            instr_id <= NOP_INST;
            valid_id <= 1'b0;
          end else if (stall) begin
            pc       <= pc;
          end else if (imem.imem_ready) begin
            instr_id    <= imem.imem_rdata;
            pc_id       <= pc;
            valid_id    <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            instr_id <= NOP_INST;
            valid_id <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign imem.imem_req  = (state == RUN);
  assign imem.imem_addr = pc;

  // Decode sees a no-op when IF/ID is empty or the pipe is being held.
  assign bubble = !valid_id | stall;

  assign opcode = instr_id[6:0];
  assign rd     = instr_id[11:7];
  assign func3  = instr_id[14:12];
  assign rs1    = instr_id[19:15];
  assign rs2    = instr_id[24:20];
  assign func7  = instr_id[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table, a few
// multi-cycle sequences and a randomized run against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump_take;
  logic [31:0] jump_target;
  logic        ready;
  logic        ovr_en;
  logic [31:0] ovr_val;

  logic [31:0] instr_id, pc_id, fetch_count;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rs1, rs2, rd;
  logic        bubble;

  int tests_run = 0;
  int tests_failed = 0;

  // Instruction memory contents: address in the upper half, an R-type opcode below.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0033};
  endfunction

  fetch_stage_if bus();

  assign bus.imem_rdata = ovr_en ? ovr_val : mem_word(bus.imem_addr);
  assign bus.imem_ready = ready;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .stall      (stall),
    .jumpTake   (jump_take),
    .jumpTarget (jump_target),
    .instr_id   (instr_id),
    .pc_id      (pc_id),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .bubble     (bubble),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the pipeline should hold, in terms of delivered words.
  logic        m_running;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic        m_valid;
  logic [31:0] m_count;

  task automatic model_reset();
    m_running = 1'b0;
    m_pc      = 32'h0;
    m_instr   = NOP;
    m_pcid    = 32'h0;
    m_valid   = 1'b0;
    m_count   = 0;
  endtask

  task automatic model_edge();
    logic [31:0] word;
    word = ovr_en ? ovr_val : mem_word(m_pc);
    if (!rst_n) begin
      model_reset();
    end else if (!m_running) begin
      m_running = 1'b1;
      if (jump_take) m_pc = jump_target & ~32'd3;
    end else if (jump_take) begin
      m_pc    = jump_target & ~32'd3;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!stall) begin
      if (ready) begin
        m_instr = word;
        m_pcid  = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 4;
        m_count = m_count + 1;
      end else begin
        m_instr = NOP;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " req"},    {31'h0, bus.imem_req}, {31'h0, m_running});
    check({tag, " addr"},   bus.imem_addr, m_pc);
    check({tag, " instr"},  instr_id, m_instr);
    if (m_valid) check({tag, " pc_id"}, pc_id, m_pcid);
    check({tag, " bubble"}, {31'h0, bubble}, {31'h0, (!m_valid) | stall});
    check({tag, " count"},  fetch_count, m_count);
    check({tag, " fields"}, {opcode, func3, func7, rs1, rs2, rd},
          {m_instr[6:0], m_instr[14:12], m_instr[31:25], m_instr[19:15], m_instr[24:20], m_instr[11:7]});
  endtask

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pcid;
    logic        chk_pcid;
    logic        e_bubble;
    logic [31:0] e_count;
  } vec_t;

  vec_t vecs[15];

  initial begin
    //          stall jump tgt           rdy addr          instr         pc_id         chk bub count
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, NOP,          32'h0000_0000, 1'b1, 1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 32'h0000_0033, 32'h0000_0000, 1'b1, 1'b0, 32'd1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h0004_0033, 32'h0000_0004, 1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0102, 1'b1, 32'h0000_0100, NOP,          32'h0,         1'b0, 1'b1, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 32'h0100_0033, 32'h0000_0100, 1'b1, 1'b0, 32'd3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 32'h0100_0033, 32'h0000_0100, 1'b1, 1'b1, 32'd3};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 32'h0100_0033, 32'h0000_0100, 1'b1, 1'b1, 32'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0108, 32'h0104_0033, 32'h0000_0104, 1'b1, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0108, NOP,          32'h0,         1'b0, 1'b1, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0108, NOP,          32'h0,         1'b0, 1'b1, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_010C, 32'h0108_0033, 32'h0000_0108, 1'b1, 1'b0, 32'd5};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, NOP,          32'h0,         1'b0, 1'b1, 32'd5};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFC, NOP,          32'h0,         1'b0, 1'b1, 32'd5};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'hFFFC_0033, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd6};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 32'h0000_0033, 32'h0000_0000, 1'b1, 1'b0, 32'd7};

    rst_n = 1'b0; stall = 1'b0; jump_take = 1'b0; jump_target = 32'h0;
    ready = 1'b1; ovr_en = 1'b0; ovr_val = 32'h0;
    model_reset();

    // Reset-time outputs.
    #12;
    check("rst req",    {31'h0, bus.imem_req}, 32'h0);
    check("rst addr",   bus.imem_addr, 32'h0);
    check("rst bubble", {31'h0, bubble}, 32'h1);
    check("rst opcode", {25'h0, opcode}, 32'h13);
    check("rst instr",  instr_id, NOP);
    check("rst count",  fetch_count, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("boot req", {31'h0, bus.imem_req}, 32'h0);

    // Directed vector table, one clock edge per row.
    for (int i = 0; i < 15; i++) begin
      stall = vecs[i].stall; jump_take = vecs[i].jump;
      jump_target = vecs[i].tgt; ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d req", i),    {31'h0, bus.imem_req}, 32'h1);
      check($sformatf("vec%0d addr", i),   bus.imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d instr", i),  instr_id, vecs[i].e_instr);
      if (vecs[i].chk_pcid) check($sformatf("vec%0d pc_id", i), pc_id, vecs[i].e_pcid);
      check($sformatf("vec%0d bubble", i), {31'h0, bubble}, {31'h0, vecs[i].e_bubble});
      check($sformatf("vec%0d count", i),  fetch_count, vecs[i].e_count);
      check($sformatf("vec%0d opcode", i), {25'h0, opcode}, {25'h0, vecs[i].e_instr[6:0]});
    end
    stall = 1'b0; jump_take = 1'b0;

    // Load-use hold of a specific instruction for three cycles.
    ovr_en = 1'b1; ovr_val = 32'h0020_8133; ready = 1'b1;
    step();
    check("hold load instr", instr_id, 32'h0020_8133);
    check("hold load pc_id", pc_id, 32'h0000_0004);
    check("hold load rs1",   {27'h0, rs1}, 32'd1);
    check("hold load rs2",   {27'h0, rs2}, 32'd2);
    check("hold load rd",    {27'h0, rd}, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold instr",  instr_id, 32'h0020_8133);
      check("hold pc_id",  pc_id, 32'h0000_0004);
      check("hold addr",   bus.imem_addr, 32'h0000_0008);
      check("hold bubble", {31'h0, bubble}, 32'h1);
    end
    stall = 1'b0; ovr_en = 1'b0;
    step();
    check("resume pc_id", pc_id, 32'h0000_0008);
    check("resume addr",  bus.imem_addr, 32'h0000_000C);
    check("resume instr", instr_id, 32'h0008_0033);
    check_model("resume");

    // Reset in the middle of a fetch, then a redirect taken during BOOT.
    ready = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst instr", instr_id, NOP);
    check("midrst addr",  bus.imem_addr, 32'h0);
    check("midrst req",   {31'h0, bus.imem_req}, 32'h0);
    check("midrst count", fetch_count, 32'h0);
    @(posedge clk); #1;
    check("midrst held instr", instr_id, NOP);
    check("midrst held count", fetch_count, 32'h0);
    jump_take = 1'b1; jump_target = 32'h0000_0041;
    #3 rst_n = 1'b1;
    #1;
    step();
    check("bootjmp addr",  bus.imem_addr, 32'h0000_0040);
    check("bootjmp req",   {31'h0, bus.imem_req}, 32'h1);
    check("bootjmp instr", instr_id, NOP);
    jump_take = 1'b0;
    step();
    check("bootjmp word",  instr_id, 32'h0040_0033);
    check("bootjmp pc_id", pc_id, 32'h0000_0040);
    check_model("bootjmp");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      jump_take   = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      ready       = ($urandom_range(0, 3) != 0);
      jump_target = $urandom();
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
